// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and control patterns for the hazard controller
// Contents: hc_state_t sequencer states, REG_W_DEF, pipe_ctrl_t latch-control
// bundle and the five fixed control patterns driven onto the pipeline latches.
package hazard_pkg;

    localparam int REG_W_DEF = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        DWAIT    = 2'd2,
        HALTED   = 2'd3
    } hc_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } pipe_ctrl_t;

    // Bit order: pc, ifid, idex, exmem, memwb enables, then ifid/idex/exmem flushes.
    // Every flush bit set here has its matching enable bit set as well.
    localparam pipe_ctrl_t CTRL_FREEZE  = 8'b00000_000;
    localparam pipe_ctrl_t CTRL_ADV     = 8'b11111_000;
    localparam pipe_ctrl_t CTRL_LUSTALL = 8'b00111_010;
    localparam pipe_ctrl_t CTRL_IBUB    = 8'b01111_100;
    localparam pipe_ctrl_t CTRL_BR      = 8'b11111_111;
    localparam pipe_ctrl_t CTRL_HALT    = 8'b00001_000;

endpackage

// File: rtl/hazard_perf_cnt.sv
// rtl/hazard_perf_cnt.sv - saturating stall/flush event counters
// Ports: CLK, RST (sync active-high clear), stall (cycle with pc_en=0),
//        flush (BR cycle), stall_cycles[31:0], flush_events[31:0].
module hazard_perf_cnt (
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            if (flush && (flush_events != '1))
                flush_events <= flush_events + 32'd1;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall/flush sequencer for the 5-stage pipeline
// Inputs : CLK, RST (sync active-high), ihit/dhit handshakes, MEM-stage
//          load/store/branch/halt, EX-stage load + destination, ID-stage sources.
// Outputs: pc_en, per-latch enables, ifid/idex/exmem flushes, sticky halt.
// Option : HAZARD_PERF_CNT_EN adds stall_cycles/flush_events counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int LU_BUBBLES = 1,
    parameter int REG_W      = REG_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_branch_taken,
    input  logic             mem_halt,
    input  logic             ex_dREN,
    input  logic [REG_W-1:0] ex_wsel,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_events,
`endif
    output logic             halt
);

    localparam logic [1:0] LU_LOAD = 2'(LU_BUBBLES - 1);

    hc_state_t  state, state_n, ret_state, ret_n, eff;
    logic [1:0] lu_cnt, cnt_n;
    logic       halt_q, halt_n;
    logic       d_stall, lu;
    pipe_ctrl_t ctrl, ctrl_out;

    assign d_stall = (mem_dREN | mem_dWEN) & ~dhit;
    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign lu = ex_dREN & (ex_wsel != '0) &
                ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

    always_comb begin
        ctrl    = CTRL_FREEZE;
        ret_n   = ret_state;
        cnt_n   = lu_cnt;
        halt_n  = halt_q;
        // A completing data access resumes the interrupted state in the same
        // cycle, so no extra cycle is added beyond the miss itself.
        eff = state;
        if (state == DWAIT)
            eff = dhit ? ret_state : DWAIT;
        state_n = eff;

        case (eff)
            RUN: begin
                if (d_stall) begin
                    ctrl    = CTRL_FREEZE;
                    ret_n   = RUN;
                    state_n = DWAIT;
                end else if (mem_halt) begin
                    ctrl    = CTRL_HALT;
                    halt_n  = 1'b1;
                    state_n = HALTED;
                end else if (mem_branch_taken) begin
                    ctrl = CTRL_BR;
                end else if (lu) begin
                    ctrl = CTRL_LUSTALL;
                    if (LU_BUBBLES > 1) begin
                        cnt_n   = LU_LOAD;
                        state_n = LU_STALL;
                    end
                end else if (!ihit) begin
                    ctrl = CTRL_IBUB;
                end else begin
                    ctrl = CTRL_ADV;
                end
            end
            LU_STALL: begin
                if (d_stall) begin
                    ctrl    = CTRL_FREEZE;
                    ret_n   = LU_STALL;
                    state_n = DWAIT;
                end else if (mem_branch_taken) begin
                    ctrl    = CTRL_BR;
                    cnt_n   = 2'd0;
                    state_n = RUN;
                end else begin
                    ctrl  = CTRL_LUSTALL;
                    cnt_n = lu_cnt - 2'd1;
                    if (lu_cnt <= 2'd1)
                        state_n = RUN;
                end
            end
            DWAIT: begin
                ctrl = CTRL_FREEZE;
            end
            HALTED: begin
                ctrl   = CTRL_FREEZE;
                halt_n = 1'b1;
            end
            default: begin
                ctrl    = CTRL_FREEZE;
                state_n = RUN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            ret_state <= RUN;
            lu_cnt    <= 2'd0;
            halt_q    <= 1'b0;
        end else begin
            state     <= state_n;
            ret_state <= ret_n;
            lu_cnt    <= cnt_n;
            halt_q    <= halt_n;
        end
    end

    // Outputs are forced low while reset is held, before the state is known.
    assign ctrl_out    = RST ? CTRL_FREEZE : ctrl;
    assign pc_en       = ctrl_out.pc_en;
    assign ifid_en     = ctrl_out.ifid_en;
    assign idex_en     = ctrl_out.idex_en;
    assign exmem_en    = ctrl_out.exmem_en;
    assign memwb_en    = ctrl_out.memwb_en;
    assign ifid_flush  = ctrl_out.ifid_flush;
    assign idex_flush  = ctrl_out.idex_flush;
    assign exmem_flush = ctrl_out.exmem_flush;
    assign halt        = halt_q & ~RST;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt u_perf (
        .CLK          (CLK),
        .RST          (RST),
        .stall        (~ctrl_out.pc_en),
        .flush        (ctrl_out == CTRL_BR),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
module tb_hazard_controller;

    localparam logic [7:0] E_FREEZE = 8'b00000_000;
    localparam logic [7:0] E_ADV    = 8'b11111_000;
    localparam logic [7:0] E_LUS    = 8'b00111_010;
    localparam logic [7:0] E_IBUB   = 8'b01111_100;
    localparam logic [7:0] E_BR     = 8'b11111_111;
    localparam logic [7:0] E_HALT   = 8'b00001_000;

    logic       CLK = 1'b0;
    logic       RST, ihit, dhit, mem_dREN, mem_dWEN, mem_branch_taken, mem_halt, ex_dREN;
    logic [4:0] ex_wsel, id_rs, id_rt;
    logic       id_uses_rt;

    logic pc1, ifid1, idex1, exmem1, memwb1, fif1, fid1, fex1, halt1;
    logic pc2, ifid2, idex2, exmem2, memwb2, fif2, fid2, fex2, halt2;
    logic [7:0] c1, c2;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc1, fe1, sc2, fe2;
`endif

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    assign c1 = {pc1, ifid1, idex1, exmem1, memwb1, fif1, fid1, fex1};
    assign c2 = {pc2, ifid2, idex2, exmem2, memwb2, fif2, fid2, fex2};

    hazard_controller #(.LU_BUBBLES(1), .REG_W(5)) u_dut1 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .mem_branch_taken(mem_branch_taken), .mem_halt(mem_halt),
        .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt),
        .pc_en(pc1), .ifid_en(ifid1), .idex_en(idex1), .exmem_en(exmem1),
        .memwb_en(memwb1), .ifid_flush(fif1), .idex_flush(fid1), .exmem_flush(fex1),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(sc1), .flush_events(fe1),
`endif
        .halt(halt1)
    );

    hazard_controller #(.LU_BUBBLES(2), .REG_W(5)) u_dut2 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .mem_branch_taken(mem_branch_taken), .mem_halt(mem_halt),
        .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt),
        .pc_en(pc2), .ifid_en(ifid2), .idex_en(idex2), .exmem_en(exmem2),
        .memwb_en(memwb2), .ifid_flush(fif2), .idex_flush(fid2), .exmem_flush(fex2),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(sc2), .flush_events(fe2),
`endif
        .halt(halt2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b1; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        mem_branch_taken = 1'b0; mem_halt = 1'b0; ex_dREN = 1'b0;
        ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] w, input logic [4:0] rs);
        ex_dREN = 1'b1; ex_wsel = w; id_rs = rs;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle_inputs();
        RST = 1'b1;

        // Reset held for two cycles: everything low.
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("rst_ctrl1", c1, E_FREEZE);
            chk("rst_ctrl2", c2, E_FREEZE);
            chk("rst_halt1", {7'd0, halt1}, 8'd0);
            tick();
        end
        RST = 1'b0;
        sample();
        chk("post_rst_adv", c1, E_ADV);
        chk("post_rst_halt", {7'd0, halt1}, 8'd0);
        tick();

        // Fetch miss alone gives an IF bubble.
        ihit = 1'b0;
        sample(); chk("ibub", c1, E_IBUB);
        tick(); ihit = 1'b1;

        // Load-use on rs, one bubble for dut1, two for dut2.
        set_lu(5'd8, 5'd8);
        sample(); chk("lu1_stall", c1, E_LUS); chk("lu2_stall_a", c2, E_LUS);
        tick(); idle_inputs();
        sample(); chk("lu1_release", c1, E_ADV); chk("lu2_stall_b", c2, E_LUS);
        tick();
        sample(); chk("lu2_release", c2, E_ADV);
        tick();

        // Register 0 never stalls.
        set_lu(5'd0, 5'd0);
        sample(); chk("lu_r0", c1, E_ADV); chk("lu_r0_d2", c2, E_ADV);
        tick();

        // rt match only counts when rt is actually read.
        ex_dREN = 1'b1; ex_wsel = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
        sample(); chk("lu_rt_unused", c1, E_ADV);
        tick();
        id_uses_rt = 1'b1;
        sample(); chk("lu_rt_used", c1, E_LUS);
        tick(); idle_inputs();
        sample(); chk("lu_rt_release", c1, E_ADV);
        tick(); tick();

        // Data miss of three cycles, released in the dhit cycle.
        mem_dREN = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample(); chk("dmiss_freeze", c1, E_FREEZE);
            tick();
        end
        dhit = 1'b1;
        sample(); chk("dmiss_done", c1, E_ADV);
        tick(); idle_inputs();

        // Store miss freezes as well.
        mem_dWEN = 1'b1; dhit = 1'b0;
        sample(); chk("smiss_freeze", c1, E_FREEZE);
        tick(); dhit = 1'b1;
        sample(); chk("smiss_done", c1, E_ADV);
        tick(); idle_inputs();

        // Two-bubble load-use interrupted by a two-cycle miss.
        set_lu(5'd8, 5'd8);
        sample(); chk("lu2m_a", c2, E_LUS);
        tick(); idle_inputs(); mem_dREN = 1'b1; dhit = 1'b0;
        sample(); chk("lu2m_b", c2, E_FREEZE);
        tick();
        sample(); chk("lu2m_c", c2, E_FREEZE);
        tick(); dhit = 1'b1;
        sample(); chk("lu2m_d", c2, E_LUS); chk("lu2m_d1", c1, E_ADV);
        tick(); idle_inputs();
        sample(); chk("lu2m_e", c2, E_ADV);
        tick();

        // lu held through the end of a stall is a fresh hazard.
        set_lu(5'd9, 5'd9);
        sample(); chk("lu_re_a", c2, E_LUS);
        tick();
        sample(); chk("lu_re_b", c2, E_LUS);
        tick();
        sample(); chk("lu_re_c", c2, E_LUS);
        tick(); idle_inputs();
        sample(); chk("lu_re_d", c2, E_LUS);
        tick();
        sample(); chk("lu_re_e", c2, E_ADV);
        tick();

        // Branch wins over a missing fetch.
        mem_branch_taken = 1'b1; ihit = 1'b0;
        sample(); chk("br_noihit", c1, E_BR);
        tick(); idle_inputs();

        // Branch during LU_STALL returns to RUN.
        set_lu(5'd7, 5'd7);
        sample(); chk("brlu_a", c2, E_LUS);
        tick(); idle_inputs(); mem_branch_taken = 1'b1;
        sample(); chk("brlu_b", c2, E_BR); chk("brlu_b1", c1, E_BR);
        tick(); idle_inputs();
        sample(); chk("brlu_c", c2, E_ADV);
        tick();

        // Data miss outranks branch; branch applies in the dhit cycle.
        mem_dREN = 1'b1; dhit = 1'b0; mem_branch_taken = 1'b1;
        sample(); chk("dm_br_freeze", c1, E_FREEZE);
        tick(); dhit = 1'b1;
        sample(); chk("dm_br_done", c1, E_BR);
        tick(); idle_inputs();

        // Halt: MEM/WB only for one cycle, then sticky freeze.
        mem_halt = 1'b1;
        sample(); chk("halt_first", c1, E_HALT); chk("halt_first_h", {7'd0, halt1}, 8'd0);
        tick(); idle_inputs();
        for (int i = 0; i < 10; i++) begin
            sample();
            chk("halted_ctrl", c1, E_FREEZE);
            chk("halted_flag", {7'd0, halt1}, 8'd1);
            tick();
        end
        RST = 1'b1;
        sample(); chk("halt_rst_ctrl", c1, E_FREEZE); chk("halt_rst_flag", {7'd0, halt1}, 8'd0);
        tick(); RST = 1'b0;
        sample(); chk("halt_cleared_adv", c1, E_ADV); chk("halt_cleared_flag", {7'd0, halt1}, 8'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Inputs: fetch/data memory handshakes (ihit/dhit), load-use operands from ID/EX, branch resolution and halt from MEM.
- Outputs: per-latch enable and flush for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Works alongside operand forwarding: it covers only the hazards forwarding cannot resolve.

Parameters:
- LU_BUBBLES, 1: bubbles inserted per load-use hazard. Legal range 1..3; 1 assumes MEM-stage forwarding.
- REG_W, 5: register-select width.

Ports:
- CLK  in  1  clock. One clock domain; reset is synchronous and active-high.
- RST  in  1  synchronous active-high reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- mem_dREN  in  1  MEM-stage instruction is a load.
- mem_dWEN  in  1  MEM-stage instruction is a store.
- mem_branch_taken  in  1  MEM-stage branch/jump redirects the PC.
- mem_halt  in  1  MEM-stage instruction is halt.
- ex_dREN  in  1  EX-stage instruction is a load.
- ex_wsel  in  REG_W  EX-stage destination register.
- id_rs  in  REG_W  ID-stage source register rs.
- id_rt  in  REG_W  ID-stage source register rt.
- id_uses_rt  in  1  ID-stage instruction reads rt.
- pc_en  out  1  PC load enable.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  load NOP when the matching enable is also high.
- halt  out  1  registered, sticky.

Behaviour:
- Terms:
  - d_stall = (mem_dREN|mem_dWEN) & !dhit.
  - lu = ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt)).
- States: RUN, LU_STALL, DWAIT, HALTED. Register ret_state (RUN/LU_STALL); counter lu_cnt, 2 bits.
- Reset:
  - While RST=1, all outputs are 0.
  - Next edge: state=RUN, lu_cnt=0, ret_state=RUN, halt=0.
- Output patterns:
  - FREEZE: all enables 0.
  - ADV: all enables 1, no flush.
  - LUSTALL: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1, exmem_en=memwb_en=1.
  - IBUB: pc_en=0, ifid_en=1 with ifid_flush=1, the rest 1.
  - BR: all enables 1; ifid_flush, idex_flush and exmem_flush all 1.
- RUN priority, highest first:
  1. d_stall: FREEZE, ret_state=RUN, go to DWAIT.
  2. mem_halt: only memwb_en=1, go to HALTED.
  3. mem_branch_taken: BR. Applies even with ihit=0; the wrong-path fetch is discarded.
  4. lu: LUSTALL. If LU_BUBBLES>1, lu_cnt=LU_BUBBLES-1 and go to LU_STALL.
  5. !ihit: IBUB.
  6. Otherwise: ADV.
- LU_STALL:
  - d_stall: FREEZE, ret_state=LU_STALL, go to DWAIT; lu_cnt holds.
  - mem_branch_taken: BR, lu_cnt=0, go to RUN.
  - Otherwise: LUSTALL and decrement lu_cnt; when lu_cnt==1, go to RUN.
- DWAIT:
  - While !dhit: FREEZE.
  - On dhit: return to ret_state, applying that state's rules for this cycle with d_stall=0.
- HALTED:
  - FREEZE, halt=1; leaves only on RST.
  - halt becomes 1 on the edge entering HALTED.
- Stall latency:
  - Load-use: exactly LU_BUBBLES bubbles, excluding freeze cycles.
  - Data miss: zero added cycles beyond the !dhit cycles.
- Boundary rules:
  - Register 0 never causes a load-use stall.
  - An lu term that reasserts in the cycle a LU_STALL ends is a new hazard.
  - Flushes are never asserted without their enable.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- With it: outputs stall_cycles[31:0] (count of cycles with pc_en=0) and flush_events[31:0] (count of BR cycles).
  - Both counters saturate and clear on RST.
- Without it: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- hazard_pkg holds:
  - the state enum typedef (hc_state_t: RUN, LU_STALL, DWAIT, HALTED);
  - REG_W_DEF=5;
  - the output pattern as a packed struct type (pipe_ctrl_t).
- Sub-module hazard_perf_cnt, instantiated only under HAZARD_PERF_CNT_EN.
- Load-use detect stays inline.

Test Plan:
1. Reset: RST=1 for 2 cycles, ihit=1 -> all outputs 0. First cycle after release -> ADV, halt=0.
2. Load-use: ex_dREN=1, ex_wsel=8, id_rs=8, LU_BUBBLES=1 -> one LUSTALL cycle, then ADV. Same with ex_wsel=0, or with rt match and id_uses_rt=0 -> no stall.
3. Data miss: mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> 3 FREEZE cycles, then ADV in the dhit cycle.
4. LU_BUBBLES=2: lu, then a miss of 2 cycles in LU_STALL -> LUSTALL, FREEZE, FREEZE, LUSTALL, ADV.
5. mem_branch_taken=1 with ihit=0 -> BR (pc_en=1, three flushes). Branch during LU_STALL -> BR, state RUN.
6. mem_halt=1 -> memwb_en only that cycle, then FREEZE with halt=1 held for 10 cycles; RST clears it.
